// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared encodings for the instruction fetch stage
package inst_fetch_pkg;

  // Stall-controller commands driven into the fetch stage
  localparam logic [1:0] STL_CONTINUE = 2'b00;
  localparam logic [1:0] STL_STALL    = 2'b01;
  localparam logic [1:0] STL_BUBBLE   = 2'b10;

  // Requests returned to the stall controller
  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_STALL = 2'b01;
  localparam logic [1:0] REQ_FLUSH = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DONE  = 2'b10
  } if_state_t;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch with redirect and global freeze
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [1:0]  stl_IF_i,
  input  logic        br_flag_i,
  input  logic [31:0] br_addr_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic        mem_req_o,
  output logic [31:0] mem_a_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_vld_o,
  output logic [1:0]  rq_IF_o
);

  if_state_t   state, state_nxt;
  logic [31:0] pc;        // base address of the fetch in progress
  logic [31:0] pc_q;      // base of the instruction held in inst_q
  logic [31:0] inst_q;
  logic [23:0] asm_q;     // bytes 0..2; byte 3 lands directly in inst_q
  logic [2:0]  issued;    // byte requests granted for this fetch
  logic [2:0]  received;  // bytes captured for this fetch
  logic        pend;      // a granted byte returns on mem_din_i this cycle
  logic        issue_ok;
  logic        byte_in;
  logic        last_byte;
  logic        unused_br_lsb;

  // Targets are word aligned, so the low redirect bits are dropped
  assign unused_br_lsb = ^br_addr_i[1:0];

  // Qualify issue and capture: a redirect or freeze blocks both
  always_comb begin
    issue_ok  = (state == FETCH) && rdy && !br_flag_i && (issued < 3'd4);
    byte_in   = pend && rdy && !br_flag_i && (state == FETCH);
    last_byte = byte_in && (received == 3'd3);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and outputs; redirect outranks every other event
  always_comb begin
    state_nxt  = state;
    mem_req_o  = 1'b0;
    mem_a_o    = 32'd0;
    inst_vld_o = 1'b0;
    rq_IF_o    = REQ_NONE;
    inst_o     = (stl_IF_i == STL_BUBBLE) ? INST_NOP : inst_q;
    pc_o       = pc_q;
    if (rdy) begin
      if (br_flag_i) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:    if (stl_IF_i != STL_STALL) state_nxt = FETCH;
          FETCH:   if (last_byte) state_nxt = DONE;
          DONE: begin
            if (stl_IF_i == STL_CONTINUE) begin
              inst_vld_o = 1'b1;
              state_nxt  = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
    case (state)
      IDLE:    if (stl_IF_i != STL_STALL) rq_IF_o = REQ_STALL;
      FETCH:   rq_IF_o = REQ_STALL;
      default: rq_IF_o = REQ_NONE;
    endcase
    if (issue_ok) begin
      mem_req_o = 1'b1;
      mem_a_o   = pc + {29'd0, issued};
    end
  end

  // Datapath: counters, byte assembly, PC update
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= 32'd0;
      pc_q     <= 32'd0;
      inst_q   <= INST_NOP;
      asm_q    <= 24'd0;
      issued   <= 3'd0;
      received <= 3'd0;
      pend     <= 1'b0;
    end else if (!rdy) begin
      // Frozen: a byte arriving now is lost, so its request must be reissued
      pend <= 1'b0;
      if (pend) issued <= received;
    end else if (br_flag_i) begin
      pc       <= {br_addr_i[31:2], 2'b00};
      issued   <= 3'd0;
      received <= 3'd0;
      pend     <= 1'b0;
    end else begin
      pend <= issue_ok && mem_grant_i;
      if (issue_ok && mem_grant_i) issued <= issued + 3'd1;
      if (byte_in) begin
        received <= received + 3'd1;
        case (received[1:0])
          2'd0:    asm_q[7:0]   <= mem_din_i;
          2'd1:    asm_q[15:8]  <= mem_din_i;
          2'd2:    asm_q[23:16] <= mem_din_i;
          default: begin
            inst_q <= {mem_din_i, asm_q};
            pc_q   <= pc;
          end
        endcase
      end
      if (inst_vld_o) begin
        pc       <= pc + 32'd4;
        issued   <= 3'd0;
        received <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with directed and random phases
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [1:0]  stl_IF_i = STL_STALL;
  logic        br_flag_i = 1'b0;
  logic [31:0] br_addr_i = 32'd0;
  logic        mem_grant_i = 1'b1;
  logic [7:0]  mem_din_i = 8'd0;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_vld_o;
  logic [1:0]  rq_IF_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];   // next instruction address the stream must deliver
  logic        prev_vld = 1'b0;
  logic [31:0] mon_e;
  logic        rsp_g;
  logic [31:0] rsp_a;

  inst_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stl_IF_i(stl_IF_i),
    .br_flag_i(br_flag_i), .br_addr_i(br_addr_i),
    .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
    .mem_req_o(mem_req_o), .mem_a_o(mem_a_o), .pc_o(pc_o),
    .inst_o(inst_o), .inst_vld_o(inst_vld_o), .rq_IF_o(rq_IF_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24];
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return mem_req_o;
      1:       return rq_IF_o == REQ_NONE;
      default: return inst_vld_o;
    endcase
  endfunction

  task automatic wait_until(input int sel, input string name);
    int n = 0;
    while (!cond(sel)) begin
      if (n == 50) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout, got 0 expected 1", name);
        return;
      end
      @(negedge clk);
      #4;
      n++;
    end
  endtask

  task automatic do_branch(input logic [31:0] a);
    br_flag_i = 1'b1;
    br_addr_i = a;
    if (rdy) begin
      exp_q.delete();
      exp_q.push_back({a[31:2], 2'b00});
    end
  endtask

  // Memory model: a granted request returns its byte during the next cycle
  always begin
    @(negedge clk);
    #3;
    rsp_g = mem_req_o && mem_grant_i;
    rsp_a = mem_a_o;
    @(posedge clk);
    #1;
    mem_din_i = rsp_g ? mem_byte(rsp_a) : 8'($urandom);
  end

  // Monitor: pop the scoreboard whenever an instruction is presented
  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      if (inst_vld_o) begin
        chk("no_double_vld", {31'd0, prev_vld}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL vld_unexpected: got pc %h expected no instruction", pc_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("vld_pc", pc_o, mon_e);
          chk("vld_inst", inst_o, mem_word(mon_e));
          exp_q.push_back(mon_e + 32'd4);
        end
      end
      if (stl_IF_i == STL_BUBBLE) begin
        chk("bubble_nop", inst_o, INST_NOP);
        chk("bubble_novld", {31'd0, inst_vld_o}, 32'd0);
      end
      if (!rdy) chk("frozen_noreq", {31'd0, mem_req_o}, 32'd0);
    end
    prev_vld = inst_vld_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int first;
    int ngr;
    logic have_ung;
    logic [31:0] ung_a;
    logic [2:0] r;

    exp_q.push_back(32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_inst", inst_o, INST_NOP);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_vld", {31'd0, inst_vld_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_a_o, 32'd0);
    chk("rst_rq", {30'd0, rq_IF_o}, {30'd0, REQ_NONE});

    // First fetch at address 0 with continuous grant
    @(negedge clk); stl_IF_i = STL_CONTINUE; mem_grant_i = 1'b1; #4;
    chk("idle_rq", {30'd0, rq_IF_o}, {30'd0, REQ_STALL});
    first = -1;
    for (i = 0; i < 30; i++) begin
      @(negedge clk); #4;
      if (mem_req_o && first < 0) first = i;
      if (inst_vld_o) break;
    end
    chk("latency", i - first, 32'd5);
    chk("first_inst", inst_o, 32'h00100513);
    chk("first_pc", pc_o, 32'd0);
    @(negedge clk); mem_grant_i = 1'b0; #4;
    wait_until(0, "req_after_first");
    chk("next_base", mem_a_o, 32'd4);

    // Toggling grant: ungranted addresses repeat, granted ones advance
    ngr = 0; have_ung = 1'b1; ung_a = 32'd4;
    for (i = 0; i < 40; i++) begin
      @(negedge clk); mem_grant_i = (i % 2 == 0); #4;
      if (inst_vld_o) break;
      chk("toggle_rq", {30'd0, rq_IF_o}, {30'd0, REQ_STALL});
      if (mem_req_o) begin
        if (have_ung) chk("retry_addr", mem_a_o, ung_a);
        if (mem_grant_i) begin
          chk("grant_addr", mem_a_o, 32'd4 + 32'(ngr));
          ngr++;
          have_ung = 1'b0;
        end else begin
          have_ung = 1'b1;
          ung_a = mem_a_o;
        end
      end
    end
    chk("granted_bytes", ngr, 32'd4);

    // Hold DONE with Stall, then release for a single pulse
    @(negedge clk); mem_grant_i = 1'b1; #4;
    wait_until(0, "req_pc8");
    @(negedge clk); stl_IF_i = STL_STALL; #4;
    wait_until(1, "done_pc8");
    for (i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #4; end
      chk("stall_vld", {31'd0, inst_vld_o}, 32'd0);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
      chk("stall_inst", inst_o, mem_word(32'd8));
      chk("stall_pc", pc_o, 32'd8);
    end
    @(negedge clk); stl_IF_i = STL_CONTINUE; #4;
    chk("release_vld", {31'd0, inst_vld_o}, 32'd1);
    @(negedge clk); #4;
    chk("release_single", {31'd0, inst_vld_o}, 32'd0);

    // Redirect after two bytes of the fetch at 12
    wait_until(0, "req_pc12");
    @(negedge clk); #4;
    @(negedge clk); #4;
    @(negedge clk); do_branch(32'h00001006); #4;
    chk("br_vld", {31'd0, inst_vld_o}, 32'd0);
    @(negedge clk); br_flag_i = 1'b0; #4;
    wait_until(0, "req_after_br");
    chk("br_addr", mem_a_o, 32'h00001004);
    wait_until(2, "vld_after_br");

    // Freeze for two cycles after one byte has landed
    @(negedge clk); #4;
    wait_until(0, "req_pc1008");
    @(negedge clk); #4;
    @(negedge clk); rdy = 1'b0; #4;
    chk("freeze_req0", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk); #4;
    chk("freeze_req1", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk); rdy = 1'b1; #4;
    chk("reissue_addr", mem_a_o, 32'h00001009);
    wait_until(2, "vld_after_freeze");

    // Redirect coinciding with DONE+Continue, to the top of memory
    @(negedge clk); #4;
    wait_until(0, "req_pc100c");
    @(negedge clk); stl_IF_i = STL_STALL; #4;
    wait_until(1, "done_pc100c");
    @(negedge clk); stl_IF_i = STL_CONTINUE; do_branch(32'hFFFFFFFE); #4;
    chk("br_over_done", {31'd0, inst_vld_o}, 32'd0);
    @(negedge clk); br_flag_i = 1'b0; #4;
    wait_until(2, "vld_top");
    chk("top_pc", pc_o, 32'hFFFFFFFC);
    @(negedge clk); #4;
    wait_until(0, "req_wrap");
    chk("wrap_addr", mem_a_o, 32'd0);

    // Random traffic against the scoreboard
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      br_flag_i = 1'b0;
      rdy = ($urandom % 8) != 0;
      r = 3'($urandom % 8);
      stl_IF_i = (r < 3'd5) ? STL_CONTINUE : (r < 3'd7) ? STL_STALL : STL_BUBBLE;
      mem_grant_i = 1'($urandom % 2);
      if ($urandom % 50 == 0)
        do_branch(($urandom % 4 == 0) ? (32'hFFFFFFF0 | 32'($urandom % 16)) : $urandom);
      #4;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The module SHALL have these ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; 0 freezes the block.
- stl_IF_i  in  2  stall-controller command: Continue/Stall/Bubble, encodings from macro.vh.
- br_flag_i  in  1  redirect from EX; valid in the same cycle as the controller's REQ_FLUSH.
- br_addr_i  in  32  redirect target.
- mem_grant_i  in  1  memory arbiter accepts this cycle's request.
- mem_din_i  in  8  read byte, valid the cycle after a granted request.
- mem_req_o  out  1  byte-read request.
- mem_a_o  out  32  byte address.
- pc_o  out  32  PC of inst_o.
- inst_o  out  32  fetched instruction, to IF/ID.
- inst_vld_o  out  1  inst_o valid this cycle.
- rq_IF_o  out  2  REQ_STALL while a fetch is incomplete, otherwise REQ_NONE.
REQ-002 Reset SHALL be synchronous and active-high on rst, with a single clock clk.

Function
REQ-003 The FSM SHALL have exactly three states:
- IDLE
- FETCH
- DONE
REQ-004 IDLE -> FETCH SHALL occur when rdy=1 and stl_IF_i != Stall; the fetch base is pc.
REQ-005 In FETCH, mem_req_o=1 and mem_a_o=pc+issued while issued<4; issued SHALL increment only in cycles with mem_grant_i=1.
REQ-006 A byte SHALL be captured in the cycle after each granted request, little-endian.
- Byte k goes to inst[8k+7:8k].
- received counts captured bytes, 0..4.
REQ-007 When received reaches 4, the state SHALL go FETCH -> DONE. With continuous grant the minimum fetch latency is 5 cycles from leaving IDLE.
REQ-008 In DONE with stl_IF_i=Continue, the block SHALL drive inst_vld_o=1 for exactly one cycle with pc_o=fetch base, then set pc<=pc+4 and go to IDLE.
REQ-009 In DONE with stl_IF_i=Stall, the block SHALL hold DONE, inst_o and pc_o, with inst_vld_o=0 and no new memory request.
REQ-010 With stl_IF_i=Bubble, inst_o SHALL be 32'h00000013 (NOP) and inst_vld_o=0, and FSM progress SHALL be unaffected.
REQ-011 rq_IF_o SHALL be REQ_STALL in FETCH and in IDLE-with-request, and REQ_NONE in DONE.
REQ-012 On br_flag_i=1 in any state, the block SHALL:
- set pc<=br_addr_i with bits [1:0] forced to 0;
- clear issued and received;
- discard the byte returning next cycle;
- go to IDLE.
Redirect SHALL take priority over Stall, Bubble and completion.
REQ-013 When br_flag_i and DONE+Continue coincide, the block SHALL force inst_vld_o=0 and leave pc equal to the redirect target, not pc+4.
REQ-014 When rdy=0, no register SHALL change and mem_req_o SHALL be 0. An outstanding ungranted byte SHALL be reissued, and a byte returning in a rdy=0 cycle SHALL be dropped, with issued rewound to received.
REQ-015 All address arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFFFFFC+4 wraps to 0.
REQ-016 inst_vld_o SHALL never be 1 in two consecutive cycles.

Reset
REQ-017 rst=1 SHALL force the following values at the next edge, regardless of state or in-flight bytes:
- state=IDLE; pc=0; issued=0; received=0
- inst_o=32'h00000013; pc_o=0; inst_vld_o=0
- mem_req_o=0; mem_a_o=0; rq_IF_o=REQ_NONE
REQ-018 A byte returning in the cycle after reset SHALL be ignored.

Structure
REQ-019 The following SHALL live in macro.vh, shared with the stall controller:
- stall encodings Continue/Stall/Bubble;
- REQ_NONE/REQ_STALL/REQ_FLUSH;
- the NOP constant;
- the FSM state encodings.
REQ-020 The block SHALL be a single module with no sub-module; byte assembly is inline.

Verification
REQ-021 Reset, grant=1 always, memory holding 13 05 10 00 at address 0, stl=Continue -> inst_o=32'h00100513, pc_o=0, inst_vld_o=1 at cycle 5; next fetch mem_a_o=4.
REQ-022 Grant toggling 1,0,1,0 during a fetch -> the address sequence repeats each ungranted address; bytes assemble correctly; rq_IF_o=REQ_STALL until DONE.
REQ-023 DONE held with stl=Stall for 3 cycles -> inst_vld_o=0, outputs stable, mem_req_o=0; release -> one valid pulse.
REQ-024 br_flag_i=1, br_addr_i=32'h00001006 after 2 bytes received -> next mem_a_o=32'h00001004; old bytes never appear on inst_o.
REQ-025 rdy dropped for 2 cycles mid-fetch -> no state change; the dropped byte is reissued; final instruction is correct.
REQ-026 pc=32'hFFFFFFFC, fetch completes -> next base mem_a_o=0.
